// File: rtl/acia_rx_ctrl_if.sv
// Bundle between the serial receiver / ACIA register decode (master) and the
// receive controller (slave).
interface acia_rx_ctrl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       rx_dat_i;
  logic             rx_stb_i;
  logic             rd_stb_i;
  logic             clr_ovr_i;
  logic             irq_en_i;
  logic [7:0]       rd_dat_o;
  logic             rx_ready_o;
  logic             rx_full_o;
  logic [LVL_W-1:0] level_o;
  logic             overrun_o;
  logic             timeout_o;
  logic             irq_o;

  modport master (
    output rx_dat_i, rx_stb_i, rd_stb_i, clr_ovr_i, irq_en_i,
    input  rd_dat_o, rx_ready_o, rx_full_o, level_o, overrun_o, timeout_o, irq_o
  );

  modport slave (
    input  rx_dat_i, rx_stb_i, rd_stb_i, clr_ovr_i, irq_en_i,
    output rd_dat_o, rx_ready_o, rx_full_o, level_o, overrun_o, timeout_o, irq_o
  );
endinterface

// File: rtl/acia_rx_ctrl.sv
// ACIA receive controller: byte FIFO with show-ahead read, sticky overrun,
// idle timeout and a single maskable level interrupt.
module acia_rx_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int IRQ_LEVEL      = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst_ni,
  acia_rx_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             overrun_q, overrun_d;
  logic             irq_q, irq_d;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             timeout_s;

  // Next-state computation for pointers, level, flags and interrupt.
  always_comb begin
    empty_s   = (level_q == {LVL_W{1'b0}});
    full_s    = (level_q == LVL_W'(FIFO_DEPTH));
    timeout_s = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    pop_s     = bus.rd_stb_i & ~empty_s;
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push_s    = bus.rx_stb_i & (~full_s | pop_s);
    drop_s    = bus.rx_stb_i & ~push_s;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    tmo_cnt_d = tmo_cnt_q;
    overrun_d = overrun_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (bus.clr_ovr_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (push_s | pop_s | empty_s) begin
      tmo_cnt_d = {CNT_W{1'b0}};
    end else if (!timeout_s) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    irq_d = bus.irq_en_i &
            ((level_q >= LVL_W'(IRQ_LEVEL)) | timeout_s | overrun_q);
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      level_q   <= {LVL_W{1'b0}};
      tmo_cnt_q <= {CNT_W{1'b0}};
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      tmo_cnt_q <= tmo_cnt_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO storage; contents are don't-care while the level is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.rx_dat_i;
    end
  end

  assign bus.rd_dat_o   = empty_s ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.rx_ready_o = ~empty_s;
  assign bus.rx_full_o  = full_s;
  assign bus.level_o    = level_q;
  assign bus.overrun_o  = overrun_q;
  assign bus.timeout_o  = timeout_s;
  assign bus.irq_o      = irq_q;
endmodule
